// File: rtl/rew_phase_scheduler_if.sv
// Frontend/DRAM-side signal bundle of the REW ORAM phase scheduler.
// The scheduler connects through the master modport; the bench or the
// surrounding datapath connects through the slave modport.
interface rew_phase_scheduler_if #(
  parameter int CW = 5
);
  logic          ReqValid;
  logic          ReqReady;
  logic          CmdValid;
  logic          CmdReady;
  logic          CmdWrite;
  logic [CW-1:0] CmdChunk;
  logic          DataTransfer;
  logic [1:0]    Phase;
  logic          PhaseActive;
  logic          PhaseDone;
  logic          AccessDone;
  logic [CW-1:0] ROCount;

  modport master (
    input  ReqValid, CmdReady, DataTransfer,
    output ReqReady, CmdValid, CmdWrite, CmdChunk,
           Phase, PhaseActive, PhaseDone, AccessDone, ROCount
  );

  modport slave (
    output ReqValid, CmdReady, DataTransfer,
    input  ReqReady, CmdValid, CmdWrite, CmdChunk,
           Phase, PhaseActive, PhaseDone, AccessDone, ROCount
  );
endinterface

// File: rtl/rew_phase_scheduler.sv
// REW ORAM backend phase scheduler.
// Walks RW_R -> RW_W or RO_R -> RO_W per access, issuing one chunk command per
// chunk and counting returned/consumed beats. Frontend requests only start RO
// accesses; after ORAME RO accesses an RW (eviction) access is forced.
// The state encoding doubles as the Phase output (IDLE has Phase bits 00).
module rew_phase_scheduler #(
  parameter int ORAME          = 4,
  parameter int RW_R_Chunk     = 8,
  parameter int RW_W_Chunk     = 8,
  parameter int RO_R_Chunk     = 2,
  parameter int RO_W_Chunk     = 2,
  parameter int MaxOutstanding = 4,
  parameter int CW             = 5
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  rew_phase_scheduler_if.master   bus
);

  typedef enum logic [2:0] {
    ST_RW_R = 3'd0,
    ST_RW_W = 3'd1,
    ST_RO_R = 3'd2,
    ST_RO_W = 3'd3,
    ST_IDLE = 3'd4
  } state_t;

  localparam logic [CW-1:0] MAX_OUT   = CW'(MaxOutstanding);
  localparam logic [CW-1:0] RO_LIMIT  = CW'(ORAME);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t        state;
  logic [CW-1:0] iss_ctr;
  logic [CW-1:0] xfer_ctr;
  logic [CW-1:0] ro_count;
  logic          rw_due;

  logic [CW-1:0] n_chunks;
  logic [CW-1:0] iss_next;
  logic [CW-1:0] xfer_next;
  logic          active;
  logic          is_write;
  logic          cmd_valid;
  logic          cmd_fire;
  logic          xfer_ok;
  logic          phase_done;
  logic          req_accept;

  // Chunk count of the phase currently being worked on.
  always_comb begin
    n_chunks = '0;
    case (state)
      ST_RW_R: n_chunks = CW'(RW_R_Chunk);
      ST_RW_W: n_chunks = CW'(RW_W_Chunk);
      ST_RO_R: n_chunks = CW'(RO_R_Chunk);
      ST_RO_W: n_chunks = CW'(RO_W_Chunk);
      default: n_chunks = '0;
    endcase
  end

  assign active    = (state != ST_IDLE);
  assign is_write  = state[0];

  // Reads are throttled by the outstanding limit; writebacks only by N.
  assign cmd_valid = active && (iss_ctr < n_chunks) &&
                     (is_write || ((iss_ctr - xfer_ctr) < MAX_OUT));
  assign cmd_fire  = cmd_valid && bus.CmdReady;

  // A read beat with nothing outstanding is a protocol error and is dropped;
  // writeback beats may legally run ahead of their commands.
  assign xfer_ok   = bus.DataTransfer && active && (xfer_ctr < n_chunks) &&
                     (is_write || (xfer_ctr != iss_ctr));

  assign iss_next   = iss_ctr  + {{(CW-1){1'b0}}, cmd_fire};
  assign xfer_next  = xfer_ctr + {{(CW-1){1'b0}}, xfer_ok};
  assign phase_done = active && (iss_next == n_chunks) && (xfer_next == n_chunks);

  // Reset_n gates the accept pulse so it stays quiet while reset is held.
  assign req_accept = (state == ST_IDLE) && !rw_due && bus.ReqValid && Reset_n;

  assign bus.ReqReady    = req_accept;
  assign bus.CmdValid    = cmd_valid;
  assign bus.CmdWrite    = is_write;
  assign bus.CmdChunk    = iss_ctr;
  assign bus.Phase       = state[1:0];
  assign bus.PhaseActive = active;
  assign bus.PhaseDone   = phase_done;
  assign bus.AccessDone  = phase_done && is_write;
  assign bus.ROCount     = ro_count;

  // Phase sequencing, chunk/beat counters and RO-access bookkeeping.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      iss_ctr  <= '0;
      xfer_ctr <= '0;
      ro_count <= '0;
      rw_due   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          iss_ctr  <= '0;
          xfer_ctr <= '0;
          if (rw_due) begin
            state <= ST_RW_R;
          end else if (bus.ReqValid) begin
            state <= ST_RO_R;
          end
        end
        default: begin
          if (phase_done) begin
            // Clearing here leaves the counters at zero on entry to the next phase.
            iss_ctr  <= '0;
            xfer_ctr <= '0;
            case (state)
              ST_RW_R: state <= ST_RW_W;
              ST_RO_R: state <= ST_RO_W;
              ST_RW_W: begin
                state    <= ST_IDLE;
                ro_count <= '0;
                rw_due   <= 1'b0;
              end
              ST_RO_W: begin
                state    <= ST_IDLE;
                ro_count <= ro_count + ONE;
                if ((ro_count + ONE) == RO_LIMIT) begin
                  rw_due <= 1'b1;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else begin
            iss_ctr  <= iss_next;
            xfer_ctr <= xfer_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rew_phase_scheduler.sv
// Self-checking bench for rew_phase_scheduler (ORAME=2, RW chunks 4,
// RO chunks 2, MaxOutstanding=2). Expected commands and post-access ROCount
// values are queued when an access is set up and compared as the DUT emits them.
module tb_rew_phase_scheduler;
  localparam int CW = 5;
  localparam int ORAME = 2;

  logic Clock = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clock = ~Clock;

  rew_phase_scheduler_if #(.CW(CW)) bus ();

  rew_phase_scheduler #(
    .ORAME(ORAME), .RW_R_Chunk(4), .RW_W_Chunk(4), .RO_R_Chunk(2), .RO_W_Chunk(2),
    .MaxOutstanding(2), .CW(CW)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cmd_q[$];
  int         ro_q[$];
  int         mdl_ro = 0;

  bit req_v = 0, rdy_v = 0, force_dt = 0, echo_en = 0, echo_pend = 0;
  bit s_fire = 0, s_pd = 0, s_rr = 0, s_cv = 0, s_active = 0;
  logic [1:0]    s_phase = '0;
  logic [CW-1:0] s_chunk = '0;
  int fire_cnt = 0, pd_cnt = 0, ad_cnt = 0, rr_cnt = 0;
  bit ro_pend = 0;
  int ro_exp = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [17:0] out_word();
    return {bus.ReqReady, bus.CmdValid, bus.CmdWrite, bus.CmdChunk, bus.Phase,
            bus.PhaseActive, bus.PhaseDone, bus.AccessDone, bus.ROCount};
  endfunction

  // Queue the command stream and resulting ROCount of the access the model predicts next.
  task automatic push_next();
    bit rw;
    int n;
    logic [1:0] rp;
    rw = (mdl_ro == ORAME);
    n  = rw ? 4 : 2;
    rp = rw ? 2'd0 : 2'd2;
    for (int i = 0; i < n; i++) cmd_q.push_back({rp, 1'b0, 5'(i)});
    for (int i = 0; i < n; i++) cmd_q.push_back({rp | 2'd1, 1'b1, 5'(i)});
    mdl_ro = rw ? 0 : mdl_ro + 1;
    ro_q.push_back(mdl_ro);
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic cycle();
    logic [7:0] exp_cmd;
    @(posedge Clock);
    #1;
    bus.ReqValid     = req_v;
    bus.CmdReady     = rdy_v;
    bus.DataTransfer = force_dt | echo_pend;
    @(negedge Clock);
    if (ro_pend) begin
      check("ro_count", int'(bus.ROCount), ro_exp);
      ro_pend = 0;
    end
    s_cv     = bus.CmdValid;
    s_fire   = bus.CmdValid && bus.CmdReady;
    s_pd     = bus.PhaseDone;
    s_rr     = bus.ReqReady;
    s_active = bus.PhaseActive;
    s_phase  = bus.Phase;
    s_chunk  = bus.CmdChunk;
    if (s_fire) begin
      fire_cnt++;
      check("cmd_q_avail", int'(cmd_q.size() > 0), 1);
      if (cmd_q.size() > 0) begin
        exp_cmd = cmd_q.pop_front();
        check("cmd", int'({bus.Phase, bus.CmdWrite, bus.CmdChunk}), int'(exp_cmd));
        $display("cmd phase=%0d write=%0d chunk=%0d", bus.Phase, bus.CmdWrite, bus.CmdChunk);
      end
    end
    echo_pend = s_fire && echo_en;
    if (s_pd) pd_cnt++;
    if (s_rr) rr_cnt++;
    if (bus.AccessDone) begin
      ad_cnt++;
      check("acc_q_avail", int'(ro_q.size() > 0), 1);
      if (ro_q.size() > 0) begin
        ro_exp  = ro_q.pop_front();
        ro_pend = 1;
      end
    end
  endtask

  task automatic run_until_ad(input int target, input int budget);
    int k = 0;
    while (ad_cnt < target && k < budget) begin
      cycle();
      k++;
    end
    check("access_done_wait", ad_cnt, target);
  endtask

  task automatic run_one_ro(input int target);
    int k = 0;
    while (ad_cnt < target && k < 60) begin
      cycle();
      if (s_rr) req_v = 0;
      k++;
    end
    check("ro_access_wait", ad_cnt, target);
  endtask

  task automatic release_reset();
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    bus.ReqValid = 1'b0;
    bus.DataTransfer = 1'b0;
    req_v = 0;
    force_dt = 0;
    echo_pend = 0;
  endtask

  initial begin
    int base;
    int k;
    bus.ReqValid = 1'b1;
    bus.CmdReady = 1'b1;
    bus.DataTransfer = 1'b1;
    #2 Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset_outputs", int'(out_word()), 0);
    release_reset();
    cycle();
    check("idle_after_reset", int'(out_word()), 0);

    // Two RO accesses with ReqValid held, then the forced RW access.
    push_next();
    push_next();
    push_next();
    req_v = 1; rdy_v = 1; echo_en = 1;
    pd_cnt = 0; rr_cnt = 0; fire_cnt = 0;
    run_until_ad(3, 200);
    req_v = 0;
    cycle();
    check("req_ready_pulses", rr_cnt, 2);
    check("phase_done_count", pd_cnt, 6);
    check("fire_count", fire_cnt, 16);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("idle_inactive", int'(s_active), 0);

    // Outstanding-limit stall in RW_R with beats withheld.
    push_next();
    push_next();
    req_v = 1;
    run_until_ad(5, 200);
    req_v = 0;
    push_next();
    echo_en = 0;
    base = fire_cnt;
    repeat (5) cycle();
    check("rwr_stall_fires", fire_cnt - base, 2);
    check("rwr_stall_valid", int'(s_cv), 0);
    force_dt = 1;
    cycle();
    force_dt = 0;
    cycle();
    check("rwr_resume_valid", int'(s_cv), 1);
    check("rwr_resume_chunk", int'(s_chunk), 2);
    force_dt = 1;
    run_until_ad(6, 100);
    force_dt = 0;

    // RO_W with both beats before any command.
    push_next();
    req_v = 1; rdy_v = 1; echo_en = 1;
    k = 0;
    while (!(s_pd && s_phase == 2'd2) && k < 50) begin
      cycle();
      if (s_rr) req_v = 0;
      k++;
    end
    check("ro_r_done_wait", int'(s_pd && s_phase == 2'd2), 1);
    rdy_v = 0; echo_en = 0; force_dt = 1;
    cycle();
    check("row_dt1_pd", int'(s_pd), 0);
    cycle();
    check("row_dt2_pd", int'(s_pd), 0);
    force_dt = 0; rdy_v = 1;
    cycle();
    check("row_cmd1_fire", int'(s_fire), 1);
    check("row_cmd1_pd", int'(s_pd), 0);
    cycle();
    check("row_cmd2_fire", int'(s_fire), 1);
    check("row_cmd2_pd", int'(s_pd), 1);

    // Spurious beats in IDLE and in RO_R before any command.
    force_dt = 1;
    cycle();
    check("idle_dt_pd", int'(s_pd), 0);
    check("idle_dt_active", int'(s_active), 0);
    push_next();
    req_v = 1; rdy_v = 0;
    cycle();
    check("spur_accept", int'(s_rr), 1);
    req_v = 0;
    cycle();
    check("spur_ror_phase", int'(s_phase), 2);
    check("spur_ror_pd", int'(s_pd), 0);
    check("spur_ror_chunk", int'(s_chunk), 0);
    force_dt = 0; rdy_v = 1; echo_en = 1;
    cycle();
    check("spur_fire0", int'(s_fire), 1);
    cycle();
    check("spur_early_pd", int'(s_pd), 0);
    cycle();
    check("spur_final_pd", int'(s_pd), 1);
    run_until_ad(8, 50);

    // Reset in the middle of RW_R after one command.
    push_next();
    echo_en = 0;
    cycle();
    cycle();
    check("pre_reset_active", int'(s_active), 1);
    @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    bus.ReqValid = 1'b1;
    bus.CmdReady = 1'b1;
    bus.DataTransfer = 1'b1;
    #1;
    check("async_reset_outputs", int'(out_word()), 0);
    cmd_q.delete();
    ro_q.delete();
    mdl_ro = 0; ro_pend = 0; echo_pend = 0;
    repeat (2) @(negedge Clock);
    release_reset();
    cycle();
    check("idle_after_mid_reset", int'(out_word()), 0);
    push_next();
    req_v = 1; rdy_v = 1; echo_en = 1;
    run_one_ro(9);
    cycle();
    check("final_cmd_q_drained", cmd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
